instr_aligner: RTL

//  Fetch-side controller feeding the combinational instruction decoder. Issues
//  in-order 16-bit parcel fetches and buffers returned parcels in a small FIFO.

---
 rtl/aap_pkg.sv | 20 ++
 rtl/parcel_fifo.sv | 73 +++++++
 rtl/instr_aligner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/aap_pkg.sv
// Shared definitions for the fetch/align path: parcel and instruction widths,
// plus a saturating-increment helper used by the optional perf counters.
package aap_pkg;

    localparam int PARCEL_W = 16;
    localparam int IS32_BIT = 15;
    localparam int INSTR_W  = 32;

    typedef logic [PARCEL_W-1:0] parcel_t;
    typedef logic [INSTR_W-1:0]  instr_t;

    function automatic logic is32(input parcel_t p);
        return p[IS32_BIT];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/parcel_fifo.sv
// Circular parcel buffer: one push, pop of 1 or 2 parcels, synchronous clear,
// and a combinational peek at the two oldest entries.
module parcel_fifo
    import aap_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  parcel_t       push_data_i,
    input  logic          pop1_i,
    input  logic          pop2_i,
    output parcel_t       head0_o,
    output parcel_t       head1_o,
    output logic [CW-1:0] count_o
);

    parcel_t       mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pop_n;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pop_n    = pop2_i ? CW'(2) : (pop1_i ? CW'(1) : '0);
        rd_ptr_d = rd_ptr_q + AW'(pop_n);
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        count_d  = count_q + CW'(push_i) - pop_n;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q qualifies every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head0_o = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_q + AW'(1)];
    assign count_o = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && !clear_i) begin
            assert (int'(count_q) + int'(push_i) - int'(pop_n) <= DEPTH);
            assert (int'(pop_n) <= int'(count_q));
        end
    end
`endif

endmodule

// File: rtl/instr_aligner.sv
// Fetch-side aligner: credit-limited in-order parcel fetch, stale-response dropping
// after flush, and 16/32-bit instruction assembly. Optional FETCH_PERF_EN adds perf counters.
module instr_aligner
    import aap_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PCW      = 24,
    parameter logic [PCW-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [PCW-1:0]      flush_pc,
    output logic                fetch_valid,
    output logic [PCW-1:0]      fetch_addr,
    input  logic                fetch_ready,
    input  logic                resp_valid,
    input  logic [PARCEL_W-1:0] resp_data,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_is32,
    output logic [PCW-1:0]      instr_pc,
    input  logic                instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_i16,
    output logic [31:0]         perf_i32,
    output logic [31:0]         perf_drop
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = CW + 1;

    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [PCW-1:0] fetch_addr_q, fetch_addr_d;
    logic [PCW-1:0] head_pc_q, head_pc_d;
    logic [LW-1:0]  live;
    parcel_t        p0, p1;
    logic           head_is32, accept, consume, pop1, pop2, resp_drop, push;

    parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (resp_data),
        .pop1_i      (pop1),
        .pop2_i      (pop2),
        .head0_o     (p0),
        .head1_o     (p1),
        .count_o     (fifo_count)
    );

    // Drops are a subset of inflight, so live counts only parcels that will land.
    // The inflight bound keeps the counters within DEPTH while stale responses drain.
    assign live        = LW'(fifo_count) + LW'(inflight_q) - LW'(drop_q);
    assign fetch_valid = !rst && !flush && (live < LW'(DEPTH)) && (inflight_q < CW'(DEPTH));
    assign fetch_addr  = fetch_addr_q;
    assign accept      = fetch_valid && fetch_ready;

    assign head_is32   = is32(p0);
    assign instr_valid = !flush && (fifo_count != '0) && (!head_is32 || fifo_count >= CW'(2));
    assign instr       = !instr_valid ? '0 :
                         head_is32    ? {p0, p1} : {p0, {PARCEL_W{1'b0}}};
    assign instr_is32  = instr_valid && head_is32;
    assign instr_pc    = head_pc_q;

    assign consume   = instr_valid && instr_ready;
    assign pop2      = consume && head_is32;
    assign pop1      = consume && !head_is32;
    assign resp_drop = resp_valid && (flush || drop_q != '0);
    assign push      = resp_valid && !resp_drop;

    always_comb begin
        inflight_d   = inflight_q + CW'(accept) - CW'(resp_valid);
        drop_d       = drop_q - CW'(resp_drop);
        fetch_addr_d = fetch_addr_q + PCW'(accept);
        head_pc_d    = head_pc_q + (pop2 ? PCW'(2) : PCW'(pop1));
        if (flush) begin
            // Everything still outstanding after this cycle's response is stale.
            drop_d       = inflight_q - CW'(resp_valid);
            fetch_addr_d = flush_pc;
            head_pc_d    = flush_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q   <= '0;
            drop_q       <= '0;
            fetch_addr_q <= RESET_PC;
            head_pc_q    <= RESET_PC;
        end else begin
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_i16_q, perf_i32_q, perf_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i16_q  <= '0;
            perf_i32_q  <= '0;
            perf_drop_q <= '0;
        end else begin
            perf_i16_q  <= sat_inc32(perf_i16_q, pop1);
            perf_i32_q  <= sat_inc32(perf_i32_q, pop2);
            perf_drop_q <= sat_inc32(perf_drop_q, resp_drop);
        end
    end

    assign perf_i16  = perf_i16_q;
    assign perf_i32  = perf_i32_q;
    assign perf_drop = perf_drop_q;
`endif

endmodule
